// File: rtl/neuron_pkg.sv
// neuron_pkg: shared state encoding, widths and sign-magnitude field constants
package neuron_pkg;

    localparam int N_DEF    = 8;
    localparam int K_DEF    = 4;
    localparam int SIGN_BIT = N_DEF - 1;

    typedef enum logic [1:0] {ACC, FINAL, OUT} state_t;

    // One guard bit beyond clog2(K) leaves room for the bias on top of K full-scale products
    function automatic int acc_width(input int n, input int k);
        return n + $clog2(k) + 1;
    endfunction

endpackage

// File: rtl/neuron_accumulator_if.sv
// neuron_accumulator_if: product stream in, neuron result out, both valid/ready
interface neuron_accumulator_if #(parameter int N = 8);

    logic         in_valid;
    logic         in_ready;
    logic [N-1:0] prod;
    logic [N-1:0] bias;
    logic         out_valid;
    logic         out_ready;
    logic [N-1:0] out_data;
    logic         busy;

    modport master (
        output in_valid, prod, bias, out_ready,
        input  in_ready, out_valid, out_data, busy
    );

    modport slave (
        input  in_valid, prod, bias, out_ready,
        output in_ready, out_valid, out_data, busy
    );

endinterface

// File: rtl/sm_to_twos.sv
// sm_to_twos: N-bit sign-magnitude to W-bit two's complement; -0 maps to 0
module sm_to_twos #(
    parameter int N = 8,
    parameter int W = 12
) (
    input  logic [N-1:0] sm_i,
    output logic [W-1:0] tc_o
);

    logic [W-1:0] mag;

    assign mag  = {{(W-N+1){1'b0}}, sm_i[N-2:0]};
    assign tc_o = sm_i[N-1] ? -mag : mag;

endmodule

// File: rtl/neuron_accumulator.sv
// neuron_accumulator: sums K sign-magnitude products plus bias, saturates, optional ReLU (NEURON_RELU_EN)
module neuron_accumulator
    import neuron_pkg::*;
#(
    parameter int N = N_DEF,
    parameter int K = K_DEF
) (
    input  logic                 clk,
    input  logic                 rst,
    neuron_accumulator_if.slave  bus
);

    localparam int ACC_W = acc_width(N, K);
    localparam int CNT_W = (K > 1) ? $clog2(K) : 1;
    localparam logic [ACC_W-1:0] MAX_W = {{(ACC_W-N+1){1'b0}}, {(N-1){1'b1}}};

    state_t             state_q, state_d;
    logic [ACC_W-1:0]   acc_q, acc_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               out_valid_q, out_valid_d;
    logic [N-1:0]       out_data_q, out_data_d;

    logic [ACC_W-1:0]   prod_tc, bias_tc, sum, sum_abs;
    logic [N-2:0]       mag;
    logic [N-1:0]       result;
    logic               neg, in_hs, last_beat;

    sm_to_twos #(.N(N), .W(ACC_W)) u_prod (.sm_i(bus.prod), .tc_o(prod_tc));
    sm_to_twos #(.N(N), .W(ACC_W)) u_bias (.sm_i(bus.bias), .tc_o(bias_tc));

    assign in_hs     = bus.in_valid && state_q == ACC;
    assign last_beat = cnt_q == CNT_W'(K - 1);

    assign sum     = acc_q + bias_tc;
    assign neg     = sum[ACC_W-1];
    assign sum_abs = neg ? -sum : sum;
    assign mag     = (sum_abs > MAX_W) ? '1 : sum_abs[N-2:0];

`ifdef NEURON_RELU_EN
    assign result = neg ? '0 : {1'b0, mag};
`else
    assign result = {neg, mag};
`endif

    // State and datapath registers; reset discards any partial sum
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ACC;
            acc_q       <= '0;
            cnt_q       <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
        end
    end

    // Next state: K beats in ACC, one cycle in FINAL, hold OUT until accepted
    always_comb begin
        state_d = state_q;
        case (state_q)
            ACC:     state_d = (in_hs && last_beat) ? FINAL : ACC;
            FINAL:   state_d = OUT;
            OUT:     state_d = bus.out_ready ? ACC : OUT;
            default: state_d = ACC;
        endcase
    end

    // Datapath updates: accumulate on accepted beats, capture result in FINAL, drop valid on accept
    always_comb begin
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        if (in_hs) begin
            acc_d = acc_q + prod_tc;
            cnt_d = last_beat ? '0 : cnt_q + CNT_W'(1);
        end
        if (state_q == FINAL) begin
            acc_d       = '0;
            out_valid_d = 1'b1;
            out_data_d  = result;
        end
        if (state_q == OUT && bus.out_ready)
            out_valid_d = 1'b0;
    end

    assign bus.in_ready  = state_q == ACC;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.busy      = state_q != ACC || cnt_q != '0;

endmodule
